// File: rtl/dmem_arbiter_if.sv
// Signal bundle between the MEM stage, the external loader/debug port and the
// single-port data memory, as seen around dmem_arbiter.
interface dmem_arbiter_if;
    logic        p_memread;
    logic        p_memwrite;
    logic [31:0] p_addr;
    logic [31:0] p_wdata;
    logic        p_stall;
    logic [31:0] p_rdata;

    logic        x_req;
    logic        x_we;
    logic [31:0] x_addr;
    logic [31:0] x_wdata;
    logic        x_ack;
    logic [31:0] x_rdata;

    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    logic        m_read;
    logic        m_write;
    logic [31:0] m_rdata;

    // Arbiter side.
    modport slave (
        input  p_memread, p_memwrite, p_addr, p_wdata,
        output p_stall, p_rdata,
        input  x_req, x_we, x_addr, x_wdata,
        output x_ack, x_rdata,
        output m_addr, m_wdata, m_read, m_write,
        input  m_rdata
    );

    // Requester and memory side.
    modport master (
        output p_memread, p_memwrite, p_addr, p_wdata,
        input  p_stall, p_rdata,
        output x_req, x_we, x_addr, x_wdata,
        input  x_ack, x_rdata,
        input  m_addr, m_wdata, m_read, m_write,
        output m_rdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Shares one single-port data memory between the pipeline MEM stage and an
// external loader/debug port; the pipeline has priority unless the port starves.
module dmem_arbiter #(
    parameter int WAIT_CYCLES  = 2,
    parameter int STARVE_LIMIT = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    dmem_arbiter_if.slave bus
);
    localparam int WC_W = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam int SC_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
    localparam logic [WC_W-1:0] WAIT_INIT  = WC_W'(WAIT_CYCLES);
    localparam logic [SC_W-1:0] STARVE_MAX = SC_W'(STARVE_LIMIT);

    typedef enum logic [2:0] {IDLE, P_ACC, P_DONE, X_ACC, X_DONE} state_t;

    state_t          state_q, state_d;
    logic [WC_W-1:0] wait_cnt;
    logic [SC_W-1:0] starve_cnt;
    logic            acc_we;
    logic            m_read_q;
    logic [31:0]     m_addr_q, m_wdata_q;
    logic [31:0]     p_rdata_q, x_rdata_q;

    logic p_req, grant_p, grant_x, in_acc, last_cycle;
    logic p_stall_c, x_ack_c, m_write_c;

    always_comb begin
        // NOTE: every always_comb output is given a default first, so no path
        // through the case can leave it unassigned and infer a latch.
        state_d    = state_q;
        grant_p    = 1'b0;
        grant_x    = 1'b0;
        p_stall_c  = 1'b0;
        x_ack_c    = 1'b0;
        p_req      = bus.p_memread | bus.p_memwrite;
        in_acc     = (state_q == P_ACC) || (state_q == X_ACC);
        last_cycle = (wait_cnt == '0);

        case (state_q)
            IDLE: begin
                grant_x   = bus.x_req && (!p_req || starve_cnt == STARVE_MAX);
                grant_p   = p_req && !grant_x;
                p_stall_c = p_req;
                if (grant_x)      state_d = X_ACC;
                else if (grant_p) state_d = P_ACC;
            end
            P_ACC: begin
                p_stall_c = 1'b1;
                if (last_cycle) state_d = P_DONE;
            end
            // One stall-free cycle lets the pipeline advance before any new grant.
            P_DONE: state_d = IDLE;
            X_ACC: begin
                p_stall_c = p_req;
                if (last_cycle) state_d = X_DONE;
            end
            X_DONE: begin
                p_stall_c = p_req;
                x_ack_c   = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // A single write strobe, in the last cycle of the access.
        m_write_c = in_acc && acc_we && last_cycle;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the datapath registers are reset as well, so the memory sees
            // a zero address, zero data and no strobes while reset is held.
            state_q    <= IDLE;
            wait_cnt   <= '0;
            starve_cnt <= '0;
            acc_we     <= 1'b0;
            m_read_q   <= 1'b0;
            m_addr_q   <= '0;
            m_wdata_q  <= '0;
            p_rdata_q  <= '0;
            x_rdata_q  <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values of its neighbours.
            state_q <= state_d;

            if (grant_x) begin
                starve_cnt <= '0;
            end else if (bus.x_req && state_q != X_ACC && state_q != X_DONE
                         && starve_cnt != STARVE_MAX) begin
                starve_cnt <= starve_cnt + 1'b1;
            end

            if (grant_x || grant_p) begin
                m_addr_q  <= grant_x ? bus.x_addr  : bus.p_addr;
                m_wdata_q <= grant_x ? bus.x_wdata : bus.p_wdata;
                acc_we    <= grant_x ? bus.x_we    : bus.p_memwrite;
                m_read_q  <= grant_x ? !bus.x_we   : !bus.p_memwrite;
                wait_cnt  <= WAIT_INIT;
            end else if (in_acc) begin
                if (last_cycle) begin
                    m_read_q <= 1'b0;
                    if (!acc_we && state_q == P_ACC) p_rdata_q <= bus.m_rdata;
                    if (!acc_we && state_q == X_ACC) x_rdata_q <= bus.m_rdata;
                end else begin
                    wait_cnt <= wait_cnt - 1'b1;
                end
            end
        end
    end

    assign bus.p_stall = p_stall_c;
    assign bus.p_rdata = p_rdata_q;
    assign bus.x_ack   = x_ack_c;
    assign bus.x_rdata = x_rdata_q;
    assign bus.m_addr  = m_addr_q;
    assign bus.m_wdata = m_wdata_q;
    assign bus.m_read  = m_read_q;
    assign bus.m_write = m_write_c;
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a transaction-level model checked every
// cycle, plus hand-computed timing and data expectations per scenario.
module tb_dmem_arbiter;
    localparam int W = 2;
    localparam int S = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   cyc   = 0;
    int   checks = 0;
    int   errors = 0;

    dmem_arbiter_if bus ();

    dmem_arbiter #(.WAIT_CYCLES(W), .STARVE_LIMIT(S)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_word(input int i);
        case (i)
            4:       return 32'hDEADBEEF;
            5:       return 32'h0BADF00D;
            12:      return 32'hCAFEF00D;
            default: return 32'h0;
        endcase
    endfunction

    // Memory the DUT talks to: combinational read, write at the clock edge.
    logic [31:0] mem [64];
    bit          mem_loaded = 1'b0;
    assign bus.m_rdata = mem[bus.m_addr[7:2]];
    always @(posedge clk) begin
        if (!mem_loaded) begin
            for (int i = 0; i < 64; i++) mem[i] <= init_word(i);
            mem_loaded <= 1'b1;
        end else if (bus.m_write) begin
            mem[bus.m_addr[7:2]] <= bus.m_wdata;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Transaction model: who owns the memory and for how many cycles so far.
    // own: 0 none, 1 pipeline, 2 external. age 1..W+1 = access cycles, W+2 = done cycle.
    logic [31:0] ref_mem [64];
    bit          ref_loaded = 1'b0;
    int          own = 0, age = 0, starve = 0;
    logic [31:0] ma = '0, mw = '0, ep = '0, ex = '0;
    logic        mwe = 1'b0;
    bit          preq, busy;

    always @(negedge clk) begin
        if (!ref_loaded) begin
            for (int i = 0; i < 64; i++) ref_mem[i] = init_word(i);
            ref_loaded = 1'b1;
        end
        preq = bus.p_memread | bus.p_memwrite;
        if (!rst_n) begin
            own = 0; age = 0; starve = 0; ep = '0; ex = '0;
            check("rst_m_read",  {31'b0, bus.m_read},  32'd0);
            check("rst_m_write", {31'b0, bus.m_write}, 32'd0);
            check("rst_x_ack",   {31'b0, bus.x_ack},   32'd0);
            check("rst_m_addr",  bus.m_addr,  32'd0);
            check("rst_m_wdata", bus.m_wdata, 32'd0);
            check("rst_p_rdata", bus.p_rdata, 32'd0);
            check("rst_x_rdata", bus.x_rdata, 32'd0);
            check("rst_p_stall", {31'b0, bus.p_stall}, {31'b0, preq});
        end else begin
            busy = (own != 0) && (age <= W + 1);
            check("cyc_p_stall", {31'b0, bus.p_stall},
                  {31'b0, (own == 1) ? (age <= W + 1) : preq});
            check("cyc_m_read",  {31'b0, bus.m_read},  {31'b0, busy && !mwe});
            check("cyc_m_write", {31'b0, bus.m_write}, {31'b0, busy && mwe && age == W + 1});
            check("cyc_x_ack",   {31'b0, bus.x_ack},   {31'b0, own == 2 && age == W + 2});
            check("cyc_p_rdata", bus.p_rdata, ep);
            check("cyc_x_rdata", bus.x_rdata, ex);
            if (busy) begin
                check("cyc_m_addr",  bus.m_addr,  ma);
                check("cyc_m_wdata", bus.m_wdata, mw);
            end
            // Advance the model to the next cycle.
            if (own == 0) begin
                if (bus.x_req && (!preq || starve == S)) begin
                    own = 2; age = 1; starve = 0;
                    ma = bus.x_addr; mw = bus.x_wdata; mwe = bus.x_we;
                end else begin
                    if (bus.x_req && starve < S) starve++;
                    if (preq) begin
                        own = 1; age = 1;
                        ma = bus.p_addr; mw = bus.p_wdata; mwe = bus.p_memwrite;
                    end
                end
            end else begin
                if (own == 1 && bus.x_req && starve < S) starve++;
                if (age == W + 1) begin
                    if (mwe)           ref_mem[ma[7:2]] = mw;
                    else if (own == 1) ep = ref_mem[ma[7:2]];
                    else               ex = ref_mem[ma[7:2]];
                end
                if (age == W + 2) own = 0;
                else              age++;
            end
        end
    end

    // Event counters for the hand-computed expectations.
    int n_rd = 0, n_wr = 0, wr_cyc = 0;
    logic [31:0] wr_addr = '0, wr_data = '0;
    always @(negedge clk) begin
        if (bus.m_read) n_rd++;
        if (bus.m_write) begin
            n_wr++; wr_cyc = cyc; wr_addr = bus.m_addr; wr_data = bus.m_wdata;
        end
    end

    task automatic pipe_op(input logic rd, input logic wr, input logic [31:0] a,
                           input logic [31:0] d, output int stall_n, output int done_rel);
        int start;
        bus.p_memread = rd; bus.p_memwrite = wr; bus.p_addr = a; bus.p_wdata = d;
        start = cyc; stall_n = 0; done_rel = -1;
        for (int i = 0; i < 40 && done_rel < 0; i++) begin
            @(negedge clk);
            if (bus.p_stall) stall_n++;
            else             done_rel = cyc - start + 1;
        end
        if (done_rel < 0) begin
            checks++; errors++;
            $display("FAIL pipe_timeout: got no stall release expected release within 40 cycles");
        end
        @(posedge clk); #1;
        bus.p_memread = 1'b0; bus.p_memwrite = 1'b0;
    endtask

    task automatic ext_op(input logic we, input logic [31:0] a, input logic [31:0] d,
                          output int ack_rel);
        int start;
        bus.x_req = 1'b1; bus.x_we = we; bus.x_addr = a; bus.x_wdata = d;
        start = cyc; ack_rel = -1;
        for (int i = 0; i < 60 && ack_rel < 0; i++) begin
            @(negedge clk);
            if (bus.x_ack) ack_rel = cyc - start + 1;
        end
        if (ack_rel < 0) begin
            checks++; errors++;
            $display("FAIL ext_timeout: got no x_ack expected x_ack within 60 cycles");
        end
        @(posedge clk); #1;
        bus.x_req = 1'b0; bus.x_we = 1'b0;
    endtask

    int stall_n, done_rel, done_p, ack_rel, s, nd, st_hi;
    int done_at [3];

    initial begin
        bus.p_memread = 1'b0; bus.p_memwrite = 1'b0; bus.p_addr = '0; bus.p_wdata = '0;
        bus.x_req = 1'b0; bus.x_we = 1'b0; bus.x_addr = '0; bus.x_wdata = '0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk); #1;
        check("reset_p_rdata", bus.p_rdata, 32'd0);
        check("reset_p_stall", {31'b0, bus.p_stall}, 32'd0);

        // Uncontended load.
        n_rd = 0;
        pipe_op(1'b1, 1'b0, 32'h10, 32'h0, stall_n, done_rel);
        check("load_stall_cycles", stall_n, 4);
        check("load_release_cycle", done_rel, 5);
        check("load_p_rdata", bus.p_rdata, 32'hDEADBEEF);
        check("load_m_read_cycles", n_rd, 3);

        // Uncontended store.
        n_wr = 0; s = cyc;
        pipe_op(1'b0, 1'b1, 32'h20, 32'h12345678, stall_n, done_rel);
        check("store_write_count", n_wr, 1);
        check("store_write_cycle", wr_cyc - s + 1, 4);
        check("store_m_addr", wr_addr, 32'h20);
        check("store_m_wdata", wr_data, 32'h12345678);
        check("store_mem", mem[8], 32'h12345678);

        // Simultaneous requests with no starvation history: pipeline first.
        fork
            pipe_op(1'b1, 1'b0, 32'h14, 32'h0, stall_n, done_p);
            ext_op(1'b0, 32'h30, 32'h0, ack_rel);
        join
        check("contest_pipe_release", done_p, 5);
        check("contest_ext_ack_cycle", ack_rel, 10);
        check("contest_p_rdata", bus.p_rdata, 32'h0BADF00D);
        check("contest_x_rdata", bus.x_rdata, 32'hCAFEF00D);

        // Back-to-back pipeline traffic against a held external write.
        s = cyc; nd = 0; st_hi = 0;
        fork
            ext_op(1'b1, 32'h3C, 32'hA5A50001, ack_rel);
            begin
                bus.p_memread = 1'b1; bus.p_addr = 32'h10;
                for (int i = 0; i < 60 && nd < 3; i++) begin
                    @(negedge clk);
                    if (cyc - s + 1 <= 10 && bus.p_stall) st_hi++;
                    if (!bus.p_stall) begin
                        done_at[nd] = cyc - s + 1;
                        nd++;
                        @(posedge clk); #1;
                        bus.p_addr = bus.p_addr + 32'd4;
                    end
                end
                bus.p_memread = 1'b0;
            end
        join
        check("starve_pipe_done_count", nd, 3);
        check("starve_ext_ack_cycle", ack_rel, 10);
        check("starve_stall_cycles_1_10", st_hi, 9);
        check("starve_pipe_done1", done_at[0], 5);
        check("starve_pipe_done2", done_at[1], 15);
        check("starve_pipe_done3", done_at[2], 20);
        check("starve_ext_mem", mem[15], 32'hA5A50001);

        // Reset during the 2nd access cycle of a store.
        n_wr = 0;
        bus.p_memwrite = 1'b1; bus.p_addr = 32'h28; bus.p_wdata = 32'h11112222;
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b0; bus.p_memwrite = 1'b0;
        @(negedge clk);
        check("abort_m_write", {31'b0, bus.m_write}, 32'd0);
        check("abort_m_read", {31'b0, bus.m_read}, 32'd0);
        check("abort_m_addr", bus.m_addr, 32'd0);
        check("abort_p_rdata", bus.p_rdata, 32'd0);
        @(posedge clk);
        #2 rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_write", n_wr, 0);
        check("abort_mem_untouched", mem[10], 32'd0);
        pipe_op(1'b1, 1'b0, 32'h10, 32'h0, stall_n, done_rel);
        check("after_reset_release_cycle", done_rel, 5);
        check("after_reset_p_rdata", bus.p_rdata, 32'hDEADBEEF);

        // Read and write both asserted: a single write, load data untouched.
        n_wr = 0; n_rd = 0;
        pipe_op(1'b1, 1'b1, 32'h24, 32'h55AA55AA, stall_n, done_rel);
        check("both_release_cycle", done_rel, 5);
        check("both_write_count", n_wr, 1);
        check("both_read_cycles", n_rd, 0);
        check("both_p_rdata", bus.p_rdata, 32'hDEADBEEF);
        check("both_mem", mem[9], 32'h55AA55AA);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test expected end before 200000");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter WAIT_CYCLES, default 2: extra cycles an access holds the memory, so each access occupies WAIT_CYCLES+1 cycles.
REQ-002 SHALL have parameter STARVE_LIMIT, default 8: number of denied cycles after which the external port beats the pipeline.
REQ-003 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have ports p_memread and p_memwrite, input, 1 bit each: MEM-stage access request, held while p_stall is high.
REQ-006 SHALL have ports p_addr and p_wdata, input, 32 bits each: MEM-stage address (ALU result) and store data.
REQ-007 SHALL have port p_stall, output, 1 bit: freezes the pipeline while its access is outstanding.
REQ-008 SHALL have port p_rdata, output, 32 bits: load data returned to MEM/WB.
REQ-009 SHALL have ports x_req and x_we, input, 1 bit each: external loader/debug request and write select.
REQ-010 SHALL have ports x_addr and x_wdata, input, 32 bits each: external address and write data.
REQ-011 SHALL have port x_ack, output, 1 bit: one-cycle completion pulse to the external port.
REQ-012 SHALL have port x_rdata, output, 32 bits: external read data.
REQ-013 SHALL have ports m_addr and m_wdata, output, 32 bits each: address and write data to the single-port data memory.
REQ-014 SHALL have ports m_read and m_write, output, 1 bit each: memory read and write strobes.
REQ-015 SHALL have port m_rdata, input, 32 bits: combinational read data from the memory.

Function
REQ-016 SHALL implement the states IDLE, P_ACC, P_DONE, X_ACC and X_DONE.
REQ-017 In IDLE, a pipeline request exists when (p_memread|p_memwrite)=1; an external request exists when x_req=1.
REQ-018 In IDLE, the pipeline SHALL win a contest unless starve_cnt==STARVE_LIMIT, in which case the external port wins.
REQ-019 On a grant, the block SHALL register address, write data and direction into m_*, load wait_cnt=WAIT_CYCLES, and enter P_ACC or X_ACC on the next edge.
REQ-020 In P_ACC and X_ACC, m_addr and m_wdata SHALL stay stable; m_read SHALL be held for every read cycle; m_write SHALL pulse only in the final cycle (wait_cnt==0), giving exactly one write per access.
REQ-021 wait_cnt SHALL decrement each ACC cycle; in the final cycle, read data SHALL be captured into p_rdata or x_rdata and the FSM SHALL move to P_DONE or X_DONE.
REQ-022 When p_memread and p_memwrite are both high, the access SHALL be treated as a write and p_rdata SHALL be left unchanged.
REQ-023 p_stall SHALL be combinational: 1 when (IDLE and pipeline request) or P_ACC or (X_ACC or X_DONE, with a pipeline request); 0 otherwise, including P_DONE.
REQ-024 P_DONE SHALL last one cycle with p_stall=0 so the pipeline advances; it SHALL return to IDLE with no grant evaluated that cycle.
REQ-025 X_DONE SHALL drive x_ack=1 for exactly one cycle and return to IDLE; x_req sampled in X_DONE SHALL be ignored, and the requester drops x_req after x_ack.
REQ-026 starve_cnt SHALL increment, saturating at STARVE_LIMIT, in each cycle where x_req=1 and the state is not X_ACC or X_DONE.
REQ-027 starve_cnt SHALL clear on an external grant.
REQ-028 Pipeline-to-memory load latency SHALL be WAIT_CYCLES+2 cycles from the request to the cycle where p_stall=0, when uncontended.
REQ-029 With STARVE_LIMIT=0, the external port SHALL always win a simultaneous request.

Reset
REQ-030 When rst_n=0, the block SHALL immediately and asynchronously force state=IDLE, wait_cnt=0, starve_cnt=0, m_read=m_write=0, m_addr=m_wdata=0, p_rdata=x_rdata=0 and x_ack=0.
REQ-031 A reset mid-access SHALL abort the access with no write issued afterwards; after release, the block SHALL rearbitrate from IDLE.

Verification (WAIT_CYCLES=2, STARVE_LIMIT=3)
REQ-032 Bench SHALL check: pipeline load addr 0x10 with memory holding 0xDEADBEEF -> p_stall high 4 cycles, low in cycle 5, p_rdata=0xDEADBEEF, m_read high for 3 cycles.
REQ-033 Bench SHALL check: pipeline store 0x20/0x12345678 -> m_write a single pulse in the 3rd ACC cycle with m_addr=0x20 and m_wdata=0x12345678.
REQ-034 Bench SHALL check: simultaneous pipeline and external requests with starve_cnt=0 -> pipeline served first; external x_ack follows after its own access; x_rdata correct.
REQ-035 Bench SHALL check: continuous back-to-back pipeline requests with x_req held -> external granted once starve_cnt reaches 3, and p_stall stays high during X_ACC.
REQ-036 Bench SHALL check: rst_n asserted in the 2nd P_ACC cycle of a store -> m_write never pulses, outputs are 0, and the next request completes normally.
REQ-037 Bench SHALL check: p_memread and p_memwrite both high -> one write issued and p_rdata unchanged.
